sysbus_mem_responder: RTL

//  Memory-side responder for the sysbus line protocol driven by the cache's m_bus_* initiator port.

---
 rtl/sysbus_pkg.sv | 26 ++
 rtl/sysbus_line_ram.sv | 24 ++
 rtl/sysbus_mem_responder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sysbus_pkg.sv
// Shared sysbus line-protocol constants and the memory responder state type.
package sysbus_pkg;

   localparam int BUS_DATA_WIDTH = 64;
   localparam int BUS_TAG_WIDTH  = 13;
   localparam int LINE_BITS      = 512;
   localparam int BEATS_PER_LINE = 8;

   localparam logic SYSBUS_WRITE = 1'b0;
   localparam logic SYSBUS_READ  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_WR_COMMIT,
      ST_RD_WAIT,
      ST_RD_BEAT
   } resp_state_t;

   function automatic logic tag_is_write(input logic [BUS_TAG_WIDTH-1:0] tag);
      return tag[BUS_TAG_WIDTH-1] == SYSBUS_WRITE;
   endfunction

endpackage

// File: rtl/sysbus_line_ram.sv
// Line store: LINES x 512-bit, one synchronous write port and one registered read port.
module sysbus_line_ram
   import sysbus_pkg::*;
#(
   parameter int LINES = 256,
   parameter int IDX_W = $clog2(LINES)
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [IDX_W-1:0]     waddr,
   input  logic [LINE_BITS-1:0] wdata,
   input  logic                 re,
   input  logic [IDX_W-1:0]     raddr,
   output logic [LINE_BITS-1:0] rdata
);

   logic [LINE_BITS-1:0] mem [LINES];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side sysbus responder: collects 8-beat write lines, returns 8-beat read lines.
// Optional build macro SYSBUS_MEM_CWF_EN enables critical-word-first read beat ordering.
module sysbus_mem_responder
   import sysbus_pkg::*;
#(
   parameter int MEM_LINES    = 256,
   parameter int READ_LATENCY = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      bus_reqcyc,
   output logic                      bus_reqack,
   input  logic [BUS_DATA_WIDTH-1:0] bus_req,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   output logic                      bus_respcyc,
   input  logic                      bus_respack,
   output logic [BUS_DATA_WIDTH-1:0] bus_resp,
   output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

   localparam int IDX_W = $clog2(MEM_LINES);
   localparam int CNT_W = $clog2(READ_LATENCY) + 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

   resp_state_t state_q, next_state;

   logic [IDX_W-1:0]         index_q;
   logic [BUS_TAG_WIDTH-1:0] tag_q;
   logic [BUS_TAG_WIDTH-1:0] resptag_q;
   logic [2:0]               ptr_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [LINE_BITS-1:0]     line_q;
   logic [LINE_BITS-1:0]     ram_rdata;
   logic [2:0]               start_word;
   logic [2:0]               word_sel;

   logic latch_req, store_beat, load_line, ram_we;
   logic ptr_clr, ptr_inc, cnt_load, cnt_dec;
   logic reqack, respcyc;

   // Offset and upper address bits are don't-care for line selection.
   logic unused_req;
   assign unused_req = ^{bus_req[BUS_DATA_WIDTH-1:6+IDX_W], bus_req[5:0]};

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= next_state;
   end

   always_comb begin
      next_state = state_q;
      latch_req  = 1'b0;
      store_beat = 1'b0;
      load_line  = 1'b0;
      ram_we     = 1'b0;
      ptr_clr    = 1'b0;
      ptr_inc    = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      reqack     = 1'b0;
      respcyc    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus_reqcyc) begin
               latch_req  = 1'b1;
               next_state = ST_REQACK;
            end
         end
         ST_REQACK: begin
            reqack = 1'b1;
            if (tag_is_write(tag_q)) begin
               ptr_clr    = 1'b1;
               next_state = ST_WR_DATA;
            end else begin
               cnt_load   = 1'b1;
               next_state = ST_RD_WAIT;
            end
         end
         ST_WR_DATA: begin
            if (bus_reqcyc) begin
               store_beat = 1'b1;
               next_state = ST_WR_ACK;
            end
         end
         ST_WR_ACK: begin
            reqack = 1'b1;
            if (ptr_q == 3'd7) begin
               next_state = ST_WR_COMMIT;
            end else begin
               ptr_inc    = 1'b1;
               next_state = ST_WR_DATA;
            end
         end
         ST_WR_COMMIT: begin
            ram_we     = 1'b1;
            next_state = ST_IDLE;
         end
         ST_RD_WAIT: begin
            // RAM output already reflects index_q, registered during REQACK.
            if (cnt_q == '0) begin
               load_line  = 1'b1;
               ptr_clr    = 1'b1;
               next_state = ST_RD_BEAT;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_RD_BEAT: begin
            respcyc = 1'b1;
            if (bus_respack) begin
               if (ptr_q == 3'd7) next_state = ST_IDLE;
               else               ptr_inc    = 1'b1;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q     <= '0;
         cnt_q     <= '0;
         resptag_q <= '0;
      end else begin
         if (ptr_clr)      ptr_q <= '0;
         else if (ptr_inc) ptr_q <= ptr_q + 3'd1;
         if (cnt_load)     cnt_q <= CNT_INIT;
         else if (cnt_dec) cnt_q <= cnt_q - CNT_W'(1);
         if (load_line)    resptag_q <= tag_q;
      end
   end

   always_ff @(posedge clk) begin
      if (latch_req) begin
         index_q <= bus_req[6 +: IDX_W];
         tag_q   <= bus_reqtag;
      end
      if (store_beat)     line_q[{ptr_q, 6'b0} +: BUS_DATA_WIDTH] <= bus_req;
      else if (load_line) line_q <= ram_rdata;
   end

`ifdef SYSBUS_MEM_CWF_EN
   logic [2:0] start_word_q;
   always_ff @(posedge clk) begin
      if (latch_req) start_word_q <= bus_req[5:3];
   end
   assign start_word = start_word_q;
`else
   assign start_word = 3'd0;
`endif

   assign word_sel = ptr_q + start_word;

   // A reset landing on the commit cycle must not leave a partial line behind.
   sysbus_line_ram #(
      .LINES (MEM_LINES),
      .IDX_W (IDX_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we && !reset),
      .waddr (index_q),
      .wdata (line_q),
      .re    (1'b1),
      .raddr (index_q),
      .rdata (ram_rdata)
   );

   assign bus_reqack  = reqack;
   assign bus_respcyc = respcyc;
   assign bus_resp    = respcyc ? line_q[{word_sel, 6'b0} +: BUS_DATA_WIDTH] : '0;
   assign bus_resptag = resptag_q;

endmodule
